// File: rtl/gpu_line_raster.sv
// Bresenham line rasteriser: takes one line command through a start/busy/done
// handshake, walks all pixels from (X0,Y0) to (X1,Y1) in any octant and writes
// the unclipped ones to SRAM, holding off while scan-out owns the memory.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for I_START; endpoints and colour latched on accept
// S_SETUP| one cycle: derive dx, dy, step directions and initial error
// S_DRAW | emit one pixel per cycle unless I_VIDEO_ON stalls the walk
// S_DONE | one cycle: raise the done pulse and drop busy
module gpu_line_raster #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 400,
    parameter int COORD_W   = 10,
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16
) (
    input  logic               I_CLK,
    input  logic               I_RST_N,
    input  logic               I_VIDEO_ON,
    input  logic               I_START,
    input  logic [COORD_W-1:0] I_X0,
    input  logic [COORD_W-1:0] I_Y0,
    input  logic [COORD_W-1:0] I_X1,
    input  logic [COORD_W-1:0] I_Y1,
    input  logic [DATA_W-1:0]  I_COLOR,
    output logic               O_BUSY,
    output logic               O_DONE,
    output logic [COORD_W:0]   O_PIXELS,
    output logic [ADDR_W-1:0]  O_GPU_ADDR,
    output logic [DATA_W-1:0]  O_GPU_DATA,
    output logic               O_GPU_WRITE,
    output logic               O_GPU_READ
);

    // Error term is COORD_W+2 bits signed; doubling it needs one more bit.
    localparam int EW = COORD_W + 2;
    localparam logic [COORD_W-1:0] C_ONE   = 1;
    localparam logic [COORD_W:0]   C_PIX_1 = 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [COORD_W-1:0]    r_x, r_y, r_x1, r_y1;
    logic [COORD_W-1:0]    w_x_nxt, w_y_nxt, w_x1_nxt, w_y1_nxt;
    logic signed [EW-1:0]  r_dx, r_dy, r_err;
    logic signed [EW-1:0]  w_dx_nxt, w_dy_nxt, w_err_nxt;
    logic                  r_sx, r_sy, w_sx_nxt, w_sy_nxt;
    logic                  r_busy, r_done, r_write;
    logic                  w_busy_nxt, w_done_nxt, w_write_nxt;
    logic [COORD_W:0]      r_pixels, w_pixels_nxt;
    logic [ADDR_W-1:0]     r_addr, w_addr_nxt;
    logic [DATA_W-1:0]     r_data, w_data_nxt;

    logic [COORD_W-1:0]    w_adx, w_ady;
    logic signed [EW-1:0]  w_setup_dx, w_setup_dy;
    logic signed [EW:0]    w_e2;
    logic                  w_step_x, w_step_y, w_inside, w_at_end;
    logic [ADDR_W-1:0]     w_pix_addr;

    assign w_adx      = (r_x1 > r_x) ? (r_x1 - r_x) : (r_x - r_x1);
    assign w_ady      = (r_y1 > r_y) ? (r_y1 - r_y) : (r_y - r_y1);
    assign w_setup_dx = $signed({2'b00, w_adx});
    assign w_setup_dy = -$signed({2'b00, w_ady});
    assign w_e2       = {r_err, 1'b0};
    assign w_step_x   = (w_e2 >= r_dy);
    assign w_step_y   = (w_e2 <= r_dx);
    assign w_inside   = (32'(r_x) < FB_WIDTH) && (32'(r_y) < FB_HEIGHT);
    assign w_at_end   = (r_x == r_x1) && (r_y == r_y1);
    assign w_pix_addr = ADDR_W'(r_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(r_x);

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_x1_nxt     = r_x1;
        w_y1_nxt     = r_y1;
        w_dx_nxt     = r_dx;
        w_dy_nxt     = r_dy;
        w_err_nxt    = r_err;
        w_sx_nxt     = r_sx;
        w_sy_nxt     = r_sy;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_write_nxt  = 1'b0;
        w_pixels_nxt = r_pixels;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        case (r_state)
            S_IDLE: begin
                if (I_START) begin
                    w_x_nxt      = I_X0;
                    w_y_nxt      = I_Y0;
                    w_x1_nxt     = I_X1;
                    w_y1_nxt     = I_Y1;
                    w_data_nxt   = I_COLOR;
                    w_pixels_nxt = '0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = S_SETUP;
                end
            end
            S_SETUP: begin
                w_dx_nxt    = w_setup_dx;
                w_dy_nxt    = w_setup_dy;
                w_err_nxt   = w_setup_dx + w_setup_dy;
                w_sx_nxt    = (r_x1 > r_x);
                w_sy_nxt    = (r_y1 > r_y);
                w_state_nxt = S_DRAW;
            end
            S_DRAW: begin
                if (!I_VIDEO_ON) begin
                    w_addr_nxt  = w_pix_addr;
                    w_write_nxt = w_inside;
                    if (w_inside)
                        w_pixels_nxt = r_pixels + C_PIX_1;
                    if (w_at_end) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        // Both axis updates use the pre-step error.
                        w_err_nxt = r_err;
                        if (w_step_x) begin
                            w_err_nxt = w_err_nxt + r_dy;
                            w_x_nxt   = r_sx ? (r_x + C_ONE) : (r_x - C_ONE);
                        end
                        if (w_step_y) begin
                            w_err_nxt = w_err_nxt + r_dx;
                            w_y_nxt   = r_sy ? (r_y + C_ONE) : (r_y - C_ONE);
                        end
                    end
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx     <= 1'b0;
            r_sy     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_write  <= 1'b0;
            r_pixels <= '0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_x1     <= w_x1_nxt;
            r_y1     <= w_y1_nxt;
            r_dx     <= w_dx_nxt;
            r_dy     <= w_dy_nxt;
            r_err    <= w_err_nxt;
            r_sx     <= w_sx_nxt;
            r_sy     <= w_sy_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_write  <= w_write_nxt;
            r_pixels <= w_pixels_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
        end
    end

    assign O_BUSY      = r_busy;
    assign O_DONE      = r_done;
    assign O_PIXELS    = r_pixels;
    assign O_GPU_ADDR  = r_addr;
    assign O_GPU_DATA  = r_data;
    assign O_GPU_WRITE = r_write;
    assign O_GPU_READ  = 1'b0;

endmodule

// File: tb/tb_gpu_line_raster.sv
// Bench for gpu_line_raster: directed lines from the test plan plus random
// lines with random scan-out stalls, checked against a pixel-list model.
module tb_gpu_line_raster;
    localparam int FBW = 640;
    localparam int FBH = 400;
    localparam int CW  = 10;
    localparam int AW  = 18;
    localparam int DW  = 16;
    localparam int MAXE = 4096;

    logic          clk = 1'b0;
    logic          rst_n, video_on, start;
    logic [CW-1:0] x0, y0, x1, y1;
    logic [DW-1:0] color;
    logic          busy, done, write, read;
    logic [CW:0]   pixels;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  stall_m [0:MAXE-1];
    bit  exp_wr  [0:MAXE-1];
    int  exp_ad  [0:MAXE-1];
    int  mx[$], my[$];
    int  got_addr[$];
    int  last_done_edge;

    always #5 clk = ~clk;

    gpu_line_raster dut (
        .I_CLK(clk), .I_RST_N(rst_n), .I_VIDEO_ON(video_on), .I_START(start),
        .I_X0(x0), .I_Y0(y0), .I_X1(x1), .I_Y1(y1), .I_COLOR(color),
        .O_BUSY(busy), .O_DONE(done), .O_PIXELS(pixels),
        .O_GPU_ADDR(addr), .O_GPU_DATA(data), .O_GPU_WRITE(write),
        .O_GPU_READ(read)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ordered pixel list of the line, straight from the stepping rules.
    function automatic void model(input int ax0, input int ay0, input int ax1, input int ay1);
        int dx, dy, sx, sy, err, e2, x, y;
        mx.delete(); my.delete();
        dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
        sx  = (ax1 > ax0) ? 1 : -1;
        sy  = (ay1 > ay0) ? 1 : -1;
        err = dx + dy;
        x = ax0; y = ay0;
        forever begin
            mx.push_back(x); my.push_back(y);
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    task automatic clear_stall();
        for (int i = 0; i < MAXE; i++) stall_m[i] = 1'b0;
    endtask

    // Runs one command; abort_edge > 0 applies reset at that edge after E0.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int col, input bit hold_start, input int abort_edge);
        int e, done_edge, n_unclip, k;
        model(ax0, ay0, ax1, ay1);
        for (int i = 0; i < MAXE; i++) begin exp_wr[i] = 1'b0; exp_ad[i] = 0; end
        e = 2; n_unclip = 0;
        for (int i = 0; i < mx.size(); i++) begin
            while (stall_m[e]) e++;
            if (mx[i] < FBW && my[i] < FBH) begin
                exp_wr[e] = 1'b1;
                exp_ad[e] = my[i] * FBW + mx[i];
                n_unclip++;
            end
            e++;
        end
        done_edge = e;
        got_addr.delete();
        last_done_edge = -1;
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        color = DW'(col);
        start = 1'b1;
        video_on = stall_m[0];
        @(posedge clk); #1;
        k = 1;
        forever begin
            start    = hold_start;
            video_on = stall_m[k];
            if (k == abort_edge) rst_n = 1'b0;
            @(posedge clk); #1;
            if (k == abort_edge) begin
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_write", write, 0);
                check("rst_read", read, 0);
                check("rst_addr", addr, 0);
                check("rst_data", data, 0);
                check("rst_pixels", pixels, 0);
                rst_n = 1'b1; start = 1'b0; video_on = 1'b0;
                @(posedge clk); #1;
                check("rst_no_done", done, 0);
                return;
            end
            check("write", write, exp_wr[k]);
            if (exp_wr[k]) begin
                check("addr", addr, exp_ad[k]);
                check("data", data, col & 16'hFFFF);
            end
            if (write === 1'b1) got_addr.push_back(int'(addr));
            check("done", done, (k == done_edge) ? 1 : 0);
            check("busy", busy, (k < done_edge) ? 1 : 0);
            if (done === 1'b1) last_done_edge = k;
            if (k >= done_edge) break;
            k++;
            if (k >= MAXE - 1) begin
                check("timeout", 1, 0);
                break;
            end
        end
        start = 1'b0; video_on = 1'b0;
        check("pixels", pixels, n_unclip);
        @(posedge clk); #1;
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        check("post_write", write, 0);
        check("read", read, 0);
    endtask

    initial begin
        int ax0, ay0, ax1, ay1, mode;
        rst_n = 1'b0; video_on = 1'b0; start = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        clear_stall();
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_write", write, 0);
        check("reset_addr", addr, 0);
        check("reset_pixels", pixels, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Horizontal line
        run_line(0, 0, 3, 0, 'hF00F, 1'b0, 0);
        check("horiz_n", got_addr.size(), 4);
        for (int i = 0; i < 4 && i < got_addr.size(); i++) check("horiz_addr", got_addr[i], i);
        check("horiz_done_edge", last_done_edge, 6);

        // Steep negative octant
        run_line(5, 5, 2, 1, 'h1234, 1'b0, 0);
        begin
            int steep[5] = '{3205, 2564, 1923, 1283, 642};
            check("steep_n", got_addr.size(), 5);
            for (int i = 0; i < 5 && i < got_addr.size(); i++) check("steep_addr", got_addr[i], steep[i]);
        end

        // Single point, start held high while busy
        run_line(7, 9, 7, 9, 'hABCD, 1'b1, 0);
        check("point_n", got_addr.size(), 1);
        if (got_addr.size() > 0) check("point_addr", got_addr[0], 5767);
        check("point_done_edge", last_done_edge, 3);

        // Clipping at the right edge
        run_line(638, 0, 641, 0, 'h0F0F, 1'b0, 0);
        check("clip_n", got_addr.size(), 2);
        if (got_addr.size() == 2) begin
            check("clip_a0", got_addr[0], 638);
            check("clip_a1", got_addr[1], 639);
        end
        check("clip_pixels", pixels, 2);
        check("clip_done_edge", last_done_edge, 6);

        // Stall for three cycles after the first pixel
        for (int i = 3; i <= 5; i++) stall_m[i] = 1'b1;
        run_line(0, 0, 2, 2, 'h5555, 1'b0, 0);
        clear_stall();
        check("stall_n", got_addr.size(), 3);
        if (got_addr.size() == 3) begin
            check("stall_a1", got_addr[1], 641);
            check("stall_a2", got_addr[2], 1282);
        end
        check("stall_done_edge", last_done_edge, 8);

        // Reset after ten pixels of a long line, then a fresh command
        run_line(0, 0, 100, 0, 'h7777, 1'b0, 12);
        run_line(20, 3, 24, 3, 'h2222, 1'b0, 0);
        check("after_rst_n", got_addr.size(), 5);
        if (got_addr.size() > 0) check("after_rst_first", got_addr[0], 3 * FBW + 20);

        // Random lines, random stalls, some straddling the frame edges
        for (int t = 0; t < 24; t++) begin
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                ax0 = $urandom_range(0, 40);  ax1 = $urandom_range(0, 40);
                ay0 = $urandom_range(0, 40);  ay1 = $urandom_range(0, 40);
            end else if (mode == 1) begin
                ax0 = $urandom_range(620, 660); ax1 = $urandom_range(620, 660);
                ay0 = $urandom_range(0, 30);    ay1 = $urandom_range(0, 30);
            end else begin
                ax0 = $urandom_range(0, 30);    ax1 = $urandom_range(0, 30);
                ay0 = $urandom_range(385, 415); ay1 = $urandom_range(385, 415);
            end
            for (int i = 0; i < 200; i++) stall_m[i] = ($urandom_range(0, 4) == 0);
            run_line(ax0, ay0, ax1, ay1, int'($urandom_range(0, 65535)), t[0], 0);
            clear_stall();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
